alu_multiword_seq: RTL and testbench
====================================

Name: alu_multiword_seq

Overview:
- Sequencer that runs one wide (N*WORDS-bit) arithmetic/logic operation through a single N-bit ALU word slice, one word per clock, least-significant word first.
- Carry/borrow is chained between words in a register.
- Sits between the control unit and the register file.
- Lets narrow ALU hardware serve wide operands, using a start/busy/done handshake.

Parameters:
- N, 4, word width of the ALU slice in bits
- WORDS, 4, number of words per operand; total operand width W = N*WORDS; WORDS >= 2

Ports:
- clk  input  1  rising-edge clock
- nrst  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled only when ready
- Mode  input  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 INC A, 111 DEC A
- CB_in  input  1  initial carry (ADD) or borrow (SUB); ignored for other modes
- A  input  W  operand A
- B  input  W  operand B
- busy  output  1  high while words are being processed
- done  output  1  one-cycle pulse: Result and CB_out are updated
- Result  output  W  registered result
- CB_out  output  1  final carry/borrow of the most significant word

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on nrst.
- Reset values:
  - State is IDLE; busy = 0, done = 0, Result = 0, CB_out = 0.
  - The internal word index, chain bit, operand and accumulator registers are all 0.
- State machine:
  - IDLE: when start = 1 at edge k, latch A, B, Mode and CB_in; set chain = CB_in for ADD/SUB, 0 otherwise; set idx = 0; go to RUN.
  - RUN: each edge processes word idx and writes it into the accumulator. The chain bit takes the slice carry/borrow; idx increments.
  - At the edge that processes word WORDS-1, go to DONE. In the same edge, copy the accumulator to Result and the final chain bit to CB_out.
  - DONE: lasts exactly one cycle; done = 1. A start sampled in DONE is accepted exactly as in IDLE, giving back-to-back operation; otherwise go to IDLE.
- Ready and handshake:
  - ready = (state is IDLE or DONE).
  - busy = (state == RUN).
  - start is ignored while busy; it is not queued.
- Latency: start accepted at edge k → done high in the cycle after edge k+WORDS. Throughput is one operation per WORDS+1 cycles.
- Result and CB_out hold their previous values through RUN and change only on entry to DONE.
- Word slice arithmetic (a, b are N-bit words, c is the chain bit):
  - ADD: {co, r} = a + b + c.
  - SUB: r = a - b - c mod 2^N; co = 1 iff a < b + c (unsigned).
  - INC: word 0 uses b = 1, c = 0; later words use b = 0 and the chained c. CB_out = 1 iff A was all ones.
  - DEC: word 0 subtracts 1 (c forced 1, b = 0); later words subtract the chained borrow. CB_out = 1 iff A == 0.
  - AND/OR/XOR/NOT: bitwise per word; co = 0; CB_out = 0.
- Boundary conditions:
  - Operands and Mode changing during RUN have no effect, because they are latched.
  - An undefined condition cannot occur; all 8 Mode codes are defined.
  - If nrst is asserted mid-RUN, the operation is abandoned and every output returns to its reset value immediately.

Optional Feature:
- Macro: ALU_MULTIWORD_SEQ_ZFLAG_EN.
- Defined: extra output Z (1 bit, reset 0), registered with Result on entry to DONE; Z = 1 iff the full W-bit result is 0. It is computed as a running OR across words, so no wide comparator is needed.
- Undefined: no Z port and no related logic.

Decomposition:
- Package alu_seq_pkg holds:
  - Mode code localparams (MODE_ADD … MODE_DEC).
  - The state encoding (IDLE, RUN, DONE).
- One sub-module: alu_word_slice, purely combinational, N-bit. Inputs: a, b, c, Mode, first-word flag. Outputs: r, co.
- The top level contains the FSM, index counter, operand/accumulator registers and chain register.

Test Plan (N = 4, WORDS = 4, W = 16):
1. ADD: A = 0xFFFF, B = 0x0001, CB_in = 0, start at edge k → busy during cycles k+1..k+4; done = 1 after edge k+4; Result = 0x0000; CB_out = 1.
2. SUB: A = 0x1000, B = 0x0001, CB_in = 0 → Result = 0x0FFF, CB_out = 0. Then A = 0x0000, B = 0x0001 → Result = 0xFFFF, CB_out = 1.
3. INC and DEC:
   - INC A = 0xFFFF → 0x0000, CB_out = 1.
   - INC A = 0x00FF → 0x0100, CB_out = 0.
   - DEC A = 0x0000 → 0xFFFF, CB_out = 1.
   - DEC A = 0x0100 → 0x00FF, CB_out = 0.
4. Logic: A = 0xF0A5, B = 0x0FF0:
   - AND → 0x00A0.
   - OR → 0xFFF5.
   - XOR → 0xFF55.
   - NOT → 0x0F5A.
   - CB_out = 0 for all.
   - With ZFLAG_EN: XOR of 0x1234 with itself → Z = 1.
5. Handshake and reset:
   - Pulse start again mid-RUN with different operands → ignored; the first result is unchanged.
   - Start held high through DONE → second operation begins with no IDLE cycle.
   - Assert nrst at edge k+2 of an ADD → busy, done, Result and CB_out are all 0 immediately; the next start completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multiword ALU sequencer: mode codes and FSM state encoding.
package alu_seq_pkg;

    localparam logic [2:0] MODE_ADD = 3'b000;
    localparam logic [2:0] MODE_SUB = 3'b001;
    localparam logic [2:0] MODE_AND = 3'b010;
    localparam logic [2:0] MODE_OR  = 3'b011;
    localparam logic [2:0] MODE_XOR = 3'b100;
    localparam logic [2:0] MODE_NOT = 3'b101;
    localparam logic [2:0] MODE_INC = 3'b110;
    localparam logic [2:0] MODE_DEC = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_word_slice.sv
// Combinational N-bit ALU slice; one word of a wide operation with carry/borrow chaining.
module alu_word_slice
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c,
    input  logic [2:0]   mode,
    input  logic         first,
    output logic [N-1:0] r,
    output logic         co
);

    logic [N-1:0] b_eff;
    logic         c_eff;
    logic [N:0]   sum;
    logic [N:0]   diff;

    // INC/DEC inject their +/-1 only into word 0; later words just ripple the chain bit.
    always_comb begin
        b_eff = b;
        c_eff = c;
        case (mode)
            MODE_INC: begin
                b_eff = first ? N'(1) : '0;
                c_eff = first ? 1'b0 : c;
            end
            MODE_DEC: begin
                b_eff = '0;
                c_eff = first ? 1'b1 : c;
            end
            default: ;
        endcase
    end

    // Borrow is the sign bit of the N+1-bit difference, i.e. a < b + c unsigned.
    assign sum  = {1'b0, a} + {1'b0, b_eff} + (N+1)'(c_eff);
    assign diff = {1'b0, a} - {1'b0, b_eff} - (N+1)'(c_eff);

    always_comb begin
        r  = '0;
        co = 1'b0;
        case (mode)
            MODE_ADD, MODE_INC: {co, r} = sum;
            MODE_SUB, MODE_DEC: {co, r} = diff;
            MODE_AND:           r = a & b;
            MODE_OR:            r = a | b;
            MODE_XOR:           r = a ^ b;
            MODE_NOT:           r = ~a;
            default:            ;
        endcase
    end

endmodule

// File: rtl/alu_multiword_seq.sv
// Runs one W-bit ALU operation through an N-bit slice, one word per clock, LSW first.
// Optional zero flag output Z when ALU_MULTIWORD_SEQ_ZFLAG_EN is defined.
module alu_multiword_seq
    import alu_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic [2:0]         Mode,
    input  logic               CB_in,
    input  logic [N*WORDS-1:0] A,
    input  logic [N*WORDS-1:0] B,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] Result,
    output logic               CB_out
`ifdef ALU_MULTIWORD_SEQ_ZFLAG_EN
    ,
    output logic               Z
`endif
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2:0]     mode_q, mode_d;
    logic           chain_q, chain_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   result_q, result_d;
    logic           cb_q, cb_d;
`ifdef ALU_MULTIWORD_SEQ_ZFLAG_EN
    logic           nz_q, nz_d;
    logic           z_q, z_d;
`endif

    logic [N-1:0]   word_r;
    logic           word_co;
    logic           last_word;

    // Operands shift right one word per step, so the slice always sees the low word.
    alu_word_slice #(.N(N)) u_slice (
        .a     (a_q[N-1:0]),
        .b     (b_q[N-1:0]),
        .c     (chain_q),
        .mode  (mode_q),
        .first (idx_q == '0),
        .r     (word_r),
        .co    (word_co)
    );

    assign last_word = (idx_q == IW'(WORDS - 1));

    // NOTE: every _d signal is given its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        chain_d  = chain_q;
        acc_d    = acc_q;
        result_d = result_q;
        cb_d     = cb_q;
`ifdef ALU_MULTIWORD_SEQ_ZFLAG_EN
        nz_d     = nz_q;
        z_d      = z_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    a_d     = A;
                    b_d     = B;
                    mode_d  = Mode;
                    chain_d = (Mode == MODE_ADD || Mode == MODE_SUB) ? CB_in : 1'b0;
                    acc_d   = '0;
`ifdef ALU_MULTIWORD_SEQ_ZFLAG_EN
                    nz_d    = 1'b0;
`endif
                end
            end
            RUN: begin
                a_d     = a_q >> N;
                b_d     = b_q >> N;
                acc_d   = {word_r, acc_q[W-1:N]};
                chain_d = word_co;
                idx_d   = idx_q + IW'(1);
`ifdef ALU_MULTIWORD_SEQ_ZFLAG_EN
                nz_d    = nz_q | (|word_r);
`endif
                if (last_word) begin
                    state_d  = DONE;
                    result_d = acc_d;
                    cb_d     = word_co;
`ifdef ALU_MULTIWORD_SEQ_ZFLAG_EN
                    z_d      = ~(nz_q | (|word_r));
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the datapath registers are reset too, since reset must clear them.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            chain_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            cb_q     <= 1'b0;
`ifdef ALU_MULTIWORD_SEQ_ZFLAG_EN
            nz_q     <= 1'b0;
            z_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            chain_q  <= chain_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cb_q     <= cb_d;
`ifdef ALU_MULTIWORD_SEQ_ZFLAG_EN
            nz_q     <= nz_d;
            z_q      <= z_d;
`endif
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign Result = result_q;
    assign CB_out = cb_q;
`ifdef ALU_MULTIWORD_SEQ_ZFLAG_EN
    assign Z      = z_q;
`endif

endmodule

// File: tb/tb_alu_multiword_seq.sv
// Self-checking bench for alu_multiword_seq: directed cases plus random ops against a wide-arithmetic model.
module tb_alu_multiword_seq;

    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, NOT_ = 3'd5, INC = 3'd6, DEC = 3'd7;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   Mode = '0;
    logic         CB_in = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, CB_out;
    logic [W-1:0] Result;
`ifdef ALU_MULTIWORD_SEQ_ZFLAG_EN
    logic         Z;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_multiword_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk    (clk),
        .nrst   (nrst),
        .start  (start),
        .Mode   (Mode),
        .CB_in  (CB_in),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .CB_out (CB_out)
`ifdef ALU_MULTIWORD_SEQ_ZFLAG_EN
        ,
        .Z      (Z)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-operand reference: {carry/borrow, result} from plain 32-bit arithmetic.
    function automatic logic [W:0] ref_op(input logic [2:0] m, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin);
        int unsigned ua = a;
        int unsigned ub = b;
        int unsigned uc = cin;
        case (m)
            ADD:  return (W+1)'(ua + ub + uc);
            SUB:  return {ua < ub + uc, W'(ua - ub - uc)};
            AND_: return {1'b0, a & b};
            OR_:  return {1'b0, a | b};
            XOR_: return {1'b0, a ^ b};
            NOT_: return {1'b0, ~a};
            INC:  return {a == {W{1'b1}}, W'(ua + 1)};
            default: return {a == '0, W'(ua - 1)};
        endcase
    endfunction

    task automatic run_op(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input bit poke);
        logic [W:0]   exp;
        logic [W-1:0] prev_r;
        logic         prev_cb;
        bit           hold_ok;
        exp = ref_op(m, a, b, cin);
        @(negedge clk);
        start = 1'b1; Mode = m; A = a; B = b; CB_in = cin;
        prev_r = Result; prev_cb = CB_out;
        @(negedge clk);
        start = 1'b0;
        hold_ok = 1'b1;
        for (int i = 0; i < WORDS; i++) begin
            if (poke && i == 0) begin
                start = 1'b1; A = W'($urandom); B = W'($urandom);
                Mode = 3'($urandom); CB_in = 1'($urandom);
            end else if (poke && i == 1) begin
                start = 1'b0;
            end
            check("busy_run", 32'(busy), 32'd1);
            if (done || Result !== prev_r || CB_out !== prev_cb) hold_ok = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("hold_run", 32'(hold_ok), 32'd1);
        check("done", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("result", 32'(Result), 32'(exp[W-1:0]));
        check("cb_out", 32'(CB_out), 32'(exp[W]));
`ifdef ALU_MULTIWORD_SEQ_ZFLAG_EN
        check("zflag", 32'(Z), 32'(exp[W-1:0] == '0));
`endif
    endtask

    initial begin
        logic [W:0] e1, e2;

        // Reset state
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(Result), 32'd0);
        check("rst_cb", 32'(CB_out), 32'd0);
        @(negedge clk);
        nrst = 1'b1;

        // Directed cases
        run_op(ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(SUB, 16'h1000, 16'h0001, 1'b0, 1'b0);
        run_op(SUB, 16'h0000, 16'h0001, 1'b0, 1'b0);
        run_op(ADD, 16'h7FFF, 16'h8000, 1'b1, 1'b0);
        run_op(SUB, 16'h0005, 16'h0004, 1'b1, 1'b0);
        run_op(INC, 16'hFFFF, 16'h1234, 1'b1, 1'b0);
        run_op(INC, 16'h00FF, 16'h0000, 1'b0, 1'b0);
        run_op(DEC, 16'h0000, 16'h0000, 1'b0, 1'b0);
        run_op(DEC, 16'h0100, 16'hFFFF, 1'b1, 1'b0);
        run_op(AND_, 16'hF0A5, 16'h0FF0, 1'b1, 1'b0);
        run_op(OR_,  16'hF0A5, 16'h0FF0, 1'b1, 1'b0);
        run_op(XOR_, 16'hF0A5, 16'h0FF0, 1'b0, 1'b0);
        run_op(NOT_, 16'hF0A5, 16'h0FF0, 1'b0, 1'b0);
        run_op(XOR_, 16'h1234, 16'h1234, 1'b0, 1'b0);

        // start pulsed mid-RUN with other operands is ignored
        run_op(ADD, 16'h0F0F, 16'h0101, 1'b0, 1'b1);

        // start held through DONE: second op begins with no IDLE cycle
        e1 = ref_op(ADD, 16'h1234, 16'h4321, 1'b1);
        e2 = ref_op(SUB, 16'h5000, 16'h0123, 1'b1);
        @(negedge clk);
        start = 1'b1; Mode = ADD; A = 16'h1234; B = 16'h4321; CB_in = 1'b1;
        @(negedge clk);
        Mode = SUB; A = 16'h5000; B = 16'h0123; CB_in = 1'b1;
        for (int i = 0; i < WORDS; i++) begin
            check("b2b_busy1", 32'(busy), 32'd1);
            @(negedge clk);
        end
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_result1", 32'(Result), 32'(e1[W-1:0]));
        check("b2b_cb1", 32'(CB_out), 32'(e1[W]));
        @(negedge clk);
        check("b2b_no_idle", 32'(busy), 32'd1);
        start = 1'b0;
        for (int i = 1; i < WORDS; i++) begin
            @(negedge clk);
            check("b2b_busy2", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_result2", 32'(Result), 32'(e2[W-1:0]));
        check("b2b_cb2", 32'(CB_out), 32'(e2[W]));

        // Reset mid-RUN: leave nonzero Result and CB_out=1 first
        run_op(ADD, 16'hFFFF, 16'h0002, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; Mode = ADD; A = 16'h1234; B = 16'h1111; CB_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 nrst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", 32'(Result), 32'd0);
        check("arst_cb", 32'(CB_out), 32'd0);
`ifdef ALU_MULTIWORD_SEQ_ZFLAG_EN
        check("arst_z", 32'(Z), 32'd0);
`endif
        @(negedge clk);
        nrst = 1'b1;
        run_op(ADD, 16'h1234, 16'h1111, 1'b0, 1'b0);

        // Randomized operations
        for (int t = 0; t < 60; t++) begin
            run_op(3'($urandom), W'($urandom), W'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
